// File: rtl/bomb_grid.sv
// bomb_grid: tile map for a bomb-placing game.
//   Every cell is EMPTY, BOMB or one of the blast codes. Players place bombs.
//   A bomb's fuse counts frame ticks. When the fuse runs out, the bomb paints
//   a cross-shaped blast. Each blast cell fades back to EMPTY after a fixed
//   number of ticks.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   tick                 frame strobe; all timers advance only when it is 1
//   put/put_cor/put_len  per-player placement request, target cell, arm length
//   put_ack              registered pulse per accepted placement
//   tile_state           registered 3-bit code per cell (cell = row*GRID_W+col)
//   explode              combinational, 1 where the cell code is a blast code
//   bomb_num             registered live-bomb count per player
// Optional feature: define BOMB_CHAIN_EN to make arms stop at bombs and chain-detonate them.
module bomb_grid #(
    parameter int GRID_W      = 16,
    parameter int GRID_H      = 16,
    parameter int NUM_PLAYERS = 2,
    parameter int BOMB_CAP    = 4,
    parameter int FUSE_TICKS  = 60,
    parameter int BLAST_TICKS = 30,
    parameter int MAX_LEN     = 4,
    localparam int CELLS = GRID_W * GRID_H,
    localparam int CW    = $clog2(CELLS),
    localparam int LW    = $clog2(MAX_LEN + 1),
    localparam int KW    = $clog2(BOMB_CAP + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      tick,
    input  logic [NUM_PLAYERS-1:0]    put,
    input  logic [NUM_PLAYERS*CW-1:0] put_cor,
    input  logic [NUM_PLAYERS*LW-1:0] put_len,
    output logic [NUM_PLAYERS-1:0]    put_ack,
    output logic [CELLS*3-1:0]        tile_state,
    output logic [CELLS-1:0]          explode,
    output logic [NUM_PLAYERS*KW-1:0] bomb_num
);
    localparam int PW   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int TMAX = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        EMPTY = 3'd0, BOMB = 3'd2, EXP_UP = 3'd3, EXP_DOWN = 3'd4,
        EXP_LEFT = 3'd5, EXP_RIGHT = 3'd6, EXP_CEN = 3'd7
    } code_e;

    // A cell runs only one timer at a time: the fuse while it holds BOMB, or the blast timer while it is lit.
    code_e          state [CELLS];
    logic [PW-1:0]  owner [CELLS];
    logic [LW-1:0]  blen  [CELLS];
    logic [TW-1:0]  cnt   [CELLS];
`ifdef BOMB_CHAIN_EN
    logic [CELLS-1:0] pend, pend_set;
`endif

    logic [NUM_PLAYERS-1:0][CW-1:0] cor;
    logic [NUM_PLAYERS-1:0][LW-1:0] plen;
    logic [NUM_PLAYERS-1:0][KW-1:0] bnum, bnum_nxt;
    logic [NUM_PLAYERS-1:0]         elig, acc;
    logic [CELLS-1:0]               det, hit, place;
    code_e                          hcode     [CELLS];
    logic [PW-1:0]                  place_own [CELLS];
    logic [LW-1:0]                  place_len [CELLS];
    logic                           run, tk;

    assign cor      = put_cor;
    assign plen     = put_len;
    assign bomb_num = bnum;
    // Inputs are ignored on the first edge after reset is released.
    assign tk       = tick & run;

    always_comb begin
        det = '0;
        for (int c = 0; c < CELLS; c++) begin
            det[c] = tk && (state[c] == BOMB) && ((cnt[c] == TW'(FUSE_TICKS - 1))
`ifdef BOMB_CHAIN_EN
                     || pend[c]
`endif
                     );
        end
    end

    // Blast painting. Centres are visited in ascending index order, so an arm
    // from a higher-index centre overwrites an arm from a lower-index one.
    // EXP_CEN is never overwritten by an arm.
    always_comb begin
        int    r, k, dr, dk;
        logic  stop;
        code_e ac;
        logic [CW-1:0] t;
        r = 0; k = 0; dr = 0; dk = 0; stop = 1'b0; ac = EMPTY; t = '0;
        hit = '0;
`ifdef BOMB_CHAIN_EN
        pend_set = '0;
`endif
        for (int c = 0; c < CELLS; c++) begin
            hcode[c] = det[c] ? EXP_CEN : EMPTY;
            hit[c]   = det[c];
        end
        for (int c = 0; c < CELLS; c++) begin
            if (det[c]) begin
                for (int dir = 0; dir < 4; dir++) begin
                    case (dir)
                        0:       begin dr = -1; dk =  0; ac = EXP_UP;    end
                        1:       begin dr =  1; dk =  0; ac = EXP_DOWN;  end
                        2:       begin dr =  0; dk = -1; ac = EXP_LEFT;  end
                        default: begin dr =  0; dk =  1; ac = EXP_RIGHT; end
                    endcase
                    stop = 1'b0;
                    for (int d = 1; d <= MAX_LEN; d++) begin
                        r = c / GRID_W + dr * d;
                        k = c % GRID_W + dk * d;
                        if (!stop && d <= int'(blen[c]) &&
                            r >= 0 && r < GRID_H && k >= 0 && k < GRID_W) begin
                            t = CW'(r * GRID_W + k);
                            if (state[t] == BOMB) begin
                                // Bombs are never painted over. With chaining the arm ends here.
`ifdef BOMB_CHAIN_EN
                                pend_set[t] = 1'b1;
                                stop        = 1'b1;
`endif
                            end else if (hcode[t] != EXP_CEN) begin
                                hit[t]   = 1'b1;
                                hcode[t] = ac;
                            end
                        end else begin
                            // Arm is at its full length or has hit the grid edge.
                            stop = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Placement arbitration. Among the players eligible for a cell, the lowest index wins.
    always_comb begin
        elig = '0;
        acc  = '0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            elig[p] = run && put[p] && (state[cor[p]] == EMPTY) && !hit[cor[p]] &&
                      (bnum[p] < KW'(BOMB_CAP));
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            acc[p] = elig[p];
            for (int q = 0; q < p; q++)
                if (elig[q] && cor[q] == cor[p]) acc[p] = 1'b0;
        end
        place = '0;
        for (int c = 0; c < CELLS; c++) begin
            place_own[c] = '0;
            place_len[c] = '0;
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (acc[p]) begin
                place[cor[p]]     = 1'b1;
                place_own[cor[p]] = PW'(p);
                place_len[cor[p]] = (plen[p] == '0) ? LW'(1) :
                                    (plen[p] > LW'(MAX_LEN)) ? LW'(MAX_LEN) : plen[p];
            end
        end
    end

    // Net live-bomb count: a placement and detonations on the same edge are combined, then the result is clamped.
    always_comb begin
        int dcnt, nxt;
        dcnt = 0; nxt = 0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            dcnt = 0;
            for (int c = 0; c < CELLS; c++)
                if (det[c] && owner[c] == PW'(p)) dcnt++;
            nxt = int'(bnum[p]) + (acc[p] ? 1 : 0) - dcnt;
            if (nxt < 0) nxt = 0;
            if (nxt > BOMB_CAP) nxt = BOMB_CAP;
            bnum_nxt[p] = KW'(nxt);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run     <= 1'b0;
            put_ack <= '0;
            bnum    <= '0;
            for (int c = 0; c < CELLS; c++) begin
                state[c] <= EMPTY;
                owner[c] <= '0;
                blen[c]  <= '0;
                cnt[c]   <= '0;
            end
`ifdef BOMB_CHAIN_EN
            pend <= '0;
`endif
        end else begin
            run     <= 1'b1;
            put_ack <= acc;
            bnum    <= bnum_nxt;
            for (int c = 0; c < CELLS; c++) begin
                if (hit[c]) begin
                    state[c] <= hcode[c];
                    cnt[c]   <= '0;
                end else if (place[c]) begin
                    state[c] <= BOMB;
                    owner[c] <= place_own[c];
                    blen[c]  <= place_len[c];
                    cnt[c]   <= '0;
                end else if (tk && state[c] == BOMB) begin
                    cnt[c] <= cnt[c] + TW'(1);
                end else if (tk && state[c] >= EXP_UP) begin
                    if (cnt[c] == TW'(BLAST_TICKS - 1)) state[c] <= EMPTY;
                    cnt[c] <= cnt[c] + TW'(1);
                end
`ifdef BOMB_CHAIN_EN
                pend[c] <= (hit[c] || place[c]) ? 1'b0 : (pend[c] | pend_set[c]);
`endif
            end
        end
    end

    always_comb begin
        tile_state = '0;
        explode    = '0;
        for (int c = 0; c < CELLS; c++) begin
            tile_state[c*3 +: 3] = state[c];
            explode[c]           = (state[c] >= EXP_UP);
        end
    end
endmodule

// File: tb/tb_bomb_grid.sv
// tb_bomb_grid: scoreboard bench for bomb_grid (default parameters).
// The stimulus task steps a tick-level game model and queues the expected outputs.
// A negedge monitor pops the queue and compares against the DUT.
module tb_bomb_grid;
    localparam int W = 16, H = 16, CELLS = 256, NP = 2, CW = 8, LW = 3, KW = 3;
    localparam int CAP = 4, FUSE = 60, BLAST = 30, MAXL = 4;

    logic                 clk = 1'b0, reset_n = 1'b0, tick = 1'b0;
    logic [NP-1:0]        put = '0;
    logic [NP*CW-1:0]     put_cor = '0;
    logic [NP*LW-1:0]     put_len = '0;
    logic [NP-1:0]        put_ack;
    logic [CELLS*3-1:0]   tile_state;
    logic [CELLS-1:0]     explode;
    logic [NP*KW-1:0]     bomb_num;

    bomb_grid dut (.clk(clk), .reset_n(reset_n), .tick(tick), .put(put), .put_cor(put_cor),
                   .put_len(put_len), .put_ack(put_ack), .tile_state(tile_state),
                   .explode(explode), .bomb_num(bomb_num));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    typedef struct {
        logic [NP-1:0]      ack;
        logic [NP*KW-1:0]   bn;
        logic [CELLS*3-1:0] tiles;
    } exp_t;
    exp_t q[$];
    exp_t me;

    // Game model: one entry per cell, with plain integer codes and counters.
    int m_st[CELLS], m_own[CELLS], m_len[CELLS], m_cnt[CELLS];
    bit m_pend[CELLS];
    int m_bn[NP];
    bit m_run;
    logic [NP-1:0] m_ack;

    function automatic void model_clear();
        for (int c = 0; c < CELLS; c++) begin
            m_st[c] = 0; m_own[c] = 0; m_len[c] = 0; m_cnt[c] = 0; m_pend[c] = 0;
        end
        for (int p = 0; p < NP; p++) m_bn[p] = 0;
        m_run = 0;
        m_ack = '0;
    endfunction

    function automatic void model_step(input logic [NP-1:0] p, input int c0, input int c1,
                                       input int l0, input int l1, input bit tk);
        int w[CELLS]; bit pn[CELLS]; bit det[CELLS]; bit placed[CELLS];
        int cor[NP]; int ln[NP]; int dec[NP];
        int dr, dk, code, r, k, t, len;
        logic [NP-1:0] acc;
        if (!m_run) begin
            m_run = 1;
            m_ack = '0;
            return;
        end
        cor[0] = c0; cor[1] = c1; ln[0] = l0; ln[1] = l1;
        for (int i = 0; i < NP; i++) dec[i] = 0;
        for (int c = 0; c < CELLS; c++) begin
            w[c] = -1; pn[c] = 0; placed[c] = 0;
            det[c] = tk && m_st[c] == 2 && (m_cnt[c] == FUSE - 1 || m_pend[c]);
            if (det[c]) begin w[c] = 7; dec[m_own[c]]++; end
        end
        for (int c = 0; c < CELLS; c++) begin
            if (!det[c]) continue;
            for (int dir = 0; dir < 4; dir++) begin
                dr = (dir == 0) ? -1 : (dir == 1) ? 1 : 0;
                dk = (dir == 2) ? -1 : (dir == 3) ? 1 : 0;
                code = 3 + dir;
                for (int d = 1; d <= m_len[c]; d++) begin
                    r = c / W + dr * d;
                    k = c % W + dk * d;
                    if (r < 0 || r >= H || k < 0 || k >= W) break;
                    t = r * W + k;
                    if (m_st[t] == 2) begin
`ifdef BOMB_CHAIN_EN
                        pn[t] = 1;
                        break;
`else
                        continue;
`endif
                    end
                    if (w[t] != 7) w[t] = code;
                end
            end
        end
        acc = '0;
        for (int i = 0; i < NP; i++) begin
            len = (ln[i] == 0) ? 1 : (ln[i] > MAXL) ? MAXL : ln[i];
            if (p[i] && m_st[cor[i]] == 0 && w[cor[i]] < 0 && m_bn[i] < CAP && !placed[cor[i]]) begin
                acc[i] = 1'b1;
                placed[cor[i]] = 1;
                m_own[cor[i]] = i;
                m_len[cor[i]] = len;
            end
        end
        for (int c = 0; c < CELLS; c++) begin
            if (w[c] >= 0) begin
                m_st[c] = w[c]; m_cnt[c] = 0; m_pend[c] = 0;
            end else if (placed[c]) begin
                m_st[c] = 2; m_cnt[c] = 0; m_pend[c] = 0;
            end else begin
                if (tk && m_st[c] == 2) m_cnt[c]++;
                else if (tk && m_st[c] >= 3) begin
                    m_cnt[c]++;
                    if (m_cnt[c] == BLAST) m_st[c] = 0;
                end
                if (pn[c]) m_pend[c] = 1;
            end
        end
        for (int i = 0; i < NP; i++) begin
            m_bn[i] = m_bn[i] + (acc[i] ? 1 : 0) - dec[i];
            if (m_bn[i] < 0) m_bn[i] = 0;
            if (m_bn[i] > CAP) m_bn[i] = CAP;
        end
        m_ack = acc;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        e.ack = m_ack;
        for (int c = 0; c < CELLS; c++) e.tiles[c*3 +: 3] = 3'(m_st[c]);
        for (int i = 0; i < NP; i++) e.bn[i*KW +: KW] = KW'(m_bn[i]);
        return e;
    endfunction

    // Drive one cycle, queue the expectation for the state after the next edge, then return #1 after that edge.
    task automatic step(input logic [NP-1:0] p, input int c0, input int c1,
                        input int l0, input int l1, input bit tk);
        exp_t e;
        put = p; put_cor = {8'(c1), 8'(c0)}; put_len = {3'(l1), 3'(l0)}; tick = tk;
        if (!reset_n) model_clear();
        else model_step(p, c0, c1, l0, l1, tk);
        e = model_expect();
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n, input bit tk);
        repeat (n) step('0, 0, 0, 0, 0, tk);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int tile(input int c);
        return int'(tile_state[c*3 +: 3]);
    endfunction

    // Monitor: outputs are presented every cycle, so pop one expectation per negedge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            checks++;
            if (put_ack !== me.ack) begin
                errors++;
                $display("FAIL sb_ack: got %b expected %b", put_ack, me.ack);
            end
            checks++;
            if (bomb_num !== me.bn) begin
                errors++;
                $display("FAIL sb_bomb_num: got %h expected %h", bomb_num, me.bn);
            end
            checks++;
            if (tile_state !== me.tiles) begin
                errors++;
                for (int c = 0; c < CELLS; c++)
                    if (tile_state[c*3 +: 3] !== me.tiles[c*3 +: 3]) begin
                        $display("FAIL sb_tile cell %0d: got %0d expected %0d",
                                 c, tile_state[c*3 +: 3], me.tiles[c*3 +: 3]);
                        break;
                    end
            end
            checks++;
            for (int c = 0; c < CELLS; c++)
                if (explode[c] !== (me.tiles[c*3 +: 3] >= 3'd3)) begin
                    errors++;
                    $display("FAIL sb_explode cell %0d: got %b", c, explode[c]);
                    break;
                end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acks;
        model_clear();
        @(posedge clk); #1;
        idle(2, 1'b1);                         // reset held: all-zero expectations
        reset_n = 1'b1;
        step(2'b01, 5, 0, 1, 0, 1'b1);         // release edge: put and tick ignored
        chk("release_ack", int'(put_ack), 0);
        chk("release_tile5", tile(5), 0);

        // Single-bomb lifecycle
        step(2'b01, 17, 0, 1, 0, 1'b0);
        chk("life_ack", int'(put_ack[0]), 1);
        chk("life_bomb", tile(17), 2);
        chk("life_num1", int'(bomb_num[2:0]), 1);
        idle(59, 1'b1);
        chk("life_fuse59", tile(17), 2);
        idle(1, 1'b1);
        chk("life_cen", tile(17), 7);
        chk("life_up", tile(1), 3);
        chk("life_down", tile(33), 4);
        chk("life_left", tile(16), 5);
        chk("life_right", tile(18), 6);
        chk("life_num0", int'(bomb_num[2:0]), 0);
        idle(29, 1'b1);
        chk("life_blast29", tile(17), 7);
        idle(1, 1'b1);
        chk("life_empty", tile(17), 0);
        chk("life_arm_empty", tile(1), 0);

        // Capacity
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            step(2'b10, 0, 50 + 2 * i, 0, 1, 1'b0);
            acks += int'(put_ack[1]);
        end
        chk("cap_acks", acks, 4);
        chk("cap_num", int'(bomb_num[5:3]), 4);
        chk("cap_fifth", tile(58), 0);
        idle(90, 1'b1);

        // Collision
        step(2'b11, 100, 100, 1, 1, 1'b0);
        chk("coll_ack", int'(put_ack), 1);
        chk("coll_num1", int'(bomb_num[5:3]), 0);
        chk("coll_num0", int'(bomb_num[2:0]), 1);
        idle(90, 1'b1);

        // Edge clipping
        step(2'b01, 0, 0, 4, 0, 1'b0);
        idle(60, 1'b1);
        chk("clip_cen", tile(0), 7);
        for (int i = 1; i <= 4; i++) begin
            chk("clip_right", tile(i), 6);
            chk("clip_down", tile(16 * i), 4);
        end
        chk("clip_15", tile(15), 0);
        chk("clip_240", tile(240), 0);
        chk("clip_5", tile(5), 0);
        chk("clip_80", tile(80), 0);
        idle(30, 1'b1);

        // Chaining
        step(2'b01, 17, 0, 2, 0, 1'b0);
        idle(10, 1'b1);
        step(2'b10, 0, 19, 0, 1, 1'b0);
        idle(50, 1'b1);
        chk("chain_cen17", tile(17), 7);
        chk("chain_arm18", tile(18), 6);
        chk("chain_19_bomb", tile(19), 2);
        idle(1, 1'b1);
`ifdef BOMB_CHAIN_EN
        chk("chain_19_next", tile(19), 7);
`else
        chk("chain_19_next", tile(19), 2);
`endif
        idle(9, 1'b1);
        chk("chain_19_late", tile(19), 7);
        idle(40, 1'b1);

        // Reset mid-fuse
        step(2'b01, 17, 0, 1, 0, 1'b0);
        idle(30, 1'b1);
        reset_n = 1'b0;
        model_clear();
        q.delete();
        q.push_back(model_expect());
        #1;
        chk("rst_tiles_zero", (tile_state == '0) ? 1 : 0, 1);
        chk("rst_num_zero", int'(bomb_num), 0);
        idle(2, 1'b1);
        reset_n = 1'b1;
        idle(1, 1'b1);
        idle(70, 1'b1);
        chk("rst_no_survivor", tile(17), 0);

        // Random play
        for (int n = 0; n < 3000; n++) begin
            logic [NP-1:0] p;
            p[0] = ($urandom_range(0, 2) == 0);
            p[1] = ($urandom_range(0, 2) == 0);
            step(p, $urandom_range(0, 79), $urandom_range(0, 79),
                 $urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 3) != 0));
        end
        idle(100, 1'b1);

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bomb_grid.md
BOMB_GRID -- requirements
Module: bomb_grid

Interface
REQ-001 SHALL have parameter GRID_W, default 16, grid columns; cell index = row*GRID_W+col; CELLS=GRID_W*GRID_H, CW=$clog2(CELLS).
REQ-002 SHALL have parameter GRID_H, default 16, grid rows.
REQ-003 SHALL have parameter NUM_PLAYERS, default 2, number of bomb-placing players.
REQ-004 SHALL have parameter BOMB_CAP, default 4, maximum live bombs per player; KW=$clog2(BOMB_CAP+1).
REQ-005 SHALL have parameter FUSE_TICKS, default 60, ticks from placement to detonation.
REQ-006 SHALL have parameter BLAST_TICKS, default 30, ticks a blast cell stays lit.
REQ-007 SHALL have parameter MAX_LEN, default 4, maximum arm length; LW=$clog2(MAX_LEN+1).
REQ-008 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-009 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port tick, input, 1, frame strobe; all fuse and blast timers advance only on cycles with tick=1.
REQ-011 SHALL have port put, input, NUM_PLAYERS, per-player place request, sampled every cycle.
REQ-012 SHALL have port put_cor, input, NUM_PLAYERS*CW, per-player target cell.
REQ-013 SHALL have port put_len, input, NUM_PLAYERS*LW, per-player arm length; 0 treated as 1, values above MAX_LEN clamp to MAX_LEN.
REQ-014 SHALL have port put_ack, output, NUM_PLAYERS, registered one-cycle pulse per accepted placement.
REQ-015 SHALL have port tile_state, output, CELLS*3, registered cell codes: 0 EMPTY, 2 BOMB, 3 EXP_UP, 4 EXP_DOWN, 5 EXP_LEFT, 6 EXP_RIGHT, 7 EXP_CEN.
REQ-016 SHALL have port explode, output, CELLS, combinational: 1 where tile_state code >= 3.
REQ-017 SHALL have port bomb_num, output, NUM_PLAYERS*KW, registered live-bomb count per player.

Function
REQ-018 SHALL accept a put only if the target cell is EMPTY, the player's bomb_num < BOMB_CAP, and no detonation writes that cell on the same edge; the cell becomes BOMB on the next edge with owner, length and fuse count 0 stored, and bomb_num increments.
REQ-019 SHALL, when several players target the same cell in one cycle, accept only the lowest player index; the others get no put_ack.
REQ-020 SHALL increment a BOMB cell's fuse count on each tick and detonate on the tick where the count equals FUSE_TICKS-1.
REQ-021 SHALL, on detonation, write EXP_CEN to the centre and EXP_UP/DOWN/LEFT/RIGHT to up to len cells per arm on the same edge, clip arms at grid edges without wrap-around, zero every written cell's blast count, and decrement the owner's bomb_num.
REQ-022 SHALL, when two detonations write the same cell on one edge, give EXP_CEN priority over arm codes; between arm codes, the detonation with the higher centre index wins.
REQ-023 SHALL increment each blast cell's count on each tick and return the cell to EMPTY on the tick where the count equals BLAST_TICKS-1; a fresh blast write restarts the count.
REQ-024 SHALL handle a simultaneous bomb_num increment and decrement for one player as a net change of 0.
REQ-025 SHALL never let bomb_num exceed BOMB_CAP or underflow below 0.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously clear all cells to EMPTY, all fuse and blast counts, all pending flags, bomb_num and put_ack to 0; a bomb armed before reset does not survive it.
REQ-027 SHALL ignore put and tick in the cycle reset_n deasserts and resume normal operation on the following edge.

Configuration
REQ-028 SHALL, with BOMB_CHAIN_EN defined, mark a BOMB cell pending when an arm reaches it; the arm stops at that cell, the cell stays BOMB, and it detonates on the next tick regardless of fuse count.
REQ-029 SHALL, without BOMB_CHAIN_EN, let arms pass over BOMB cells without changing them or their fuse counts, and not implement pending flags.

Verification
REQ-030 SHALL cover a single-bomb lifecycle: P0 put cell 17, len 1 -> put_ack[0] next cycle, BOMB at 17; after tick 60 -> EXP_CEN at 17 and arms at 1, 16, 18, 33; bomb_num[0] 1->0; EMPTY after tick 30.
REQ-031 SHALL cover capacity: P1 puts 5 bombs at distinct empty cells with no ticks -> 4 acks, bomb_num[1]=4, fifth put gets no ack.
REQ-032 SHALL cover collision: P0 and P1 both put cell 100 in one cycle -> only put_ack[0], owner P0, bomb_num[1]=0.
REQ-033 SHALL cover edge clipping: put cell 0, len 4 -> blast only at 0, 1-4, 16, 32, 48, 64; no write to cells 15 or 240.
REQ-034 SHALL cover chaining: bomb at 17 len 2 and bomb at 19 placed 10 ticks later -> with BOMB_CHAIN_EN, 19 goes EXP_CEN one tick after 17 detonates; without BOMB_CHAIN_EN, 19 stays BOMB until its own fuse expires.
REQ-035 SHALL cover reset mid-fuse: assert reset_n=0 at fuse tick 30 -> all tile_state and bomb_num immediately 0.
